// File: rtl/dso_meas_pkg.sv
// Shared types and sizing helpers for the scope measurement blocks.
package dso_meas_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        SEED = 1'b0,
        ACC  = 1'b1
    } meas_state_t;

    function automatic int win_cnt_w(input int win_len);
        return $clog2(win_len);
    endfunction

endpackage

// File: rtl/meas_avg4.sv
// Four-slot result history with a truncating mean; the output register updates
// one cycle after each accepted result.
module meas_avg4 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_load_all,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] avg
);

    logic [W-1:0] slot_reg  [4];
    logic [W-1:0] slot_next [4];
    logic [W+1:0] sum_next;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot_next[i] = slot_reg[i];
        end
        sum_next = '0;
        if (in_valid) begin
            slot_next[0] = in_data;
            // A fresh history is filled entirely so the first mean equals the result.
            for (int i = 1; i < 4; i++) begin
                slot_next[i] = in_load_all ? in_data : slot_reg[i-1];
            end
        end
        for (int i = 0; i < 4; i++) begin
            sum_next = sum_next + (W+2)'(slot_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                slot_reg[i] <= '0;
            end
            avg <= '0;
        end else if (in_valid) begin
            for (int i = 0; i < 4; i++) begin
                slot_reg[i] <= slot_next[i];
            end
            avg <= sum_next[W+1:2];
        end
    end

endmodule

// File: rtl/adc_peak_meter.sv
// Windowed max/min/peak-to-peak meter on the ADC sample stream.
// Optional 4-window averaging of the readouts when ADC_PEAK_AVG_EN is defined.
module adc_peak_meter
    import dso_meas_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int WIN_LEN = 4096
) (
    input  logic              ad_clk,
    input  logic              rst_n,
    input  logic              i_ad_valid,
    input  logic [DATA_W-1:0] i_ad_data,
    input  logic              i_clr,
    output logic [DATA_W-1:0] o_ad_max,
    output logic [DATA_W-1:0] o_ad_min,
    output logic [DATA_W-1:0] o_ad_vpp,
    output logic              o_upd
);

    localparam int CNT_W = win_cnt_w(WIN_LEN);

    meas_state_t       state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] run_max_reg, run_max_next;
    logic [DATA_W-1:0] run_min_reg, run_min_next;
    logic [DATA_W-1:0] merged_max, merged_min;
    logic              close;

    // Result registers: index 0 = max, 1 = min, 2 = vpp.
    logic [DATA_W-1:0] res_reg [3];
    logic              res_upd_reg;

    assign merged_max = (i_ad_data > run_max_reg) ? i_ad_data : run_max_reg;
    assign merged_min = (i_ad_data < run_min_reg) ? i_ad_data : run_min_reg;

    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            state_reg   <= SEED;
            cnt_reg     <= '0;
            run_max_reg <= '0;
            run_min_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            run_max_reg <= run_max_next;
            run_min_reg <= run_min_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        run_max_next = run_max_reg;
        run_min_next = run_min_reg;
        close        = 1'b0;
        // Restart has priority over any sample in the same cycle.
        if (i_clr) begin
            state_next = SEED;
            cnt_next   = '0;
        end else if (i_ad_valid) begin
            case (state_reg)
                SEED: begin
                    run_max_next = i_ad_data;
                    run_min_next = i_ad_data;
                    cnt_next     = CNT_W'(1);
                    state_next   = ACC;
                end
                ACC: begin
                    run_max_next = merged_max;
                    run_min_next = merged_min;
                    if (cnt_reg == CNT_W'(WIN_LEN - 1)) begin
                        close      = 1'b1;
                        cnt_next   = '0;
                        state_next = SEED;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = SEED;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                res_reg[i] <= '0;
            end
            res_upd_reg <= 1'b0;
        end else begin
            res_upd_reg <= close;
            if (close) begin
                res_reg[0] <= merged_max;
                res_reg[1] <= merged_min;
                res_reg[2] <= merged_max - merged_min;
            end
        end
    end

`ifdef ADC_PEAK_AVG_EN
    logic              seed_pending_reg;
    logic              load_all_reg;
    logic              upd_reg;
    logic [DATA_W-1:0] avg_out [3];

    // The first close after reset or restart refills the whole history.
    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            seed_pending_reg <= 1'b1;
            load_all_reg     <= 1'b0;
            upd_reg          <= 1'b0;
        end else begin
            upd_reg <= res_upd_reg;
            if (close) begin
                load_all_reg     <= seed_pending_reg;
                seed_pending_reg <= 1'b0;
            end else if (i_clr) begin
                seed_pending_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_avg
            meas_avg4 #(.W(DATA_W)) u_avg (
                .clk         (ad_clk),
                .rst_n       (rst_n),
                .in_valid    (res_upd_reg),
                .in_load_all (load_all_reg),
                .in_data     (res_reg[gi]),
                .avg         (avg_out[gi])
            );
        end
    endgenerate

    assign o_ad_max = avg_out[0];
    assign o_ad_min = avg_out[1];
    assign o_ad_vpp = avg_out[2];
    assign o_upd    = upd_reg;
`else
    assign o_ad_max = res_reg[0];
    assign o_ad_min = res_reg[1];
    assign o_ad_vpp = res_reg[2];
    assign o_upd    = res_upd_reg;
`endif

endmodule

// File: tb/tb_adc_peak_meter.sv
// Self-checking bench for adc_peak_meter (WIN_LEN=8); honours ADC_PEAK_AVG_EN.
module tb_adc_peak_meter;

    localparam int WIN = 8;

    logic       ad_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_ad_valid = 1'b0;
    logic [7:0] i_ad_data = '0;
    logic       i_clr = 1'b0;
    logic [7:0] o_ad_max, o_ad_min, o_ad_vpp;
    logic       o_upd;

    int checks = 0;
    int failures = 0;
    int upd_count = 0;

    adc_peak_meter #(.DATA_W(8), .WIN_LEN(WIN)) dut (
        .ad_clk     (ad_clk),
        .rst_n      (rst_n),
        .i_ad_valid (i_ad_valid),
        .i_ad_data  (i_ad_data),
        .i_clr      (i_clr),
        .o_ad_max   (o_ad_max),
        .o_ad_min   (o_ad_min),
        .o_ad_vpp   (o_ad_vpp),
        .o_upd      (o_upd)
    );

    always #5 ad_clk = ~ad_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect each window's samples, reduce with plain max/min.
    logic [7:0] win_q[$];
    int  exp_val[3];
    bit  exp_upd = 1'b0;
    bit  started = 1'b0;
`ifdef ADC_PEAK_AVG_EN
    int  hist[3][4];
    int  pend_res[3];
    bit  pend_v = 1'b0;
    bit  pend_first = 1'b0;
    bit  first_m = 1'b1;
`endif

    always @(posedge ad_clk) begin
        int mx, mn;
        if (!rst_n) begin
            win_q.delete();
            exp_upd = 1'b0;
            for (int k = 0; k < 3; k++) exp_val[k] = 0;
`ifdef ADC_PEAK_AVG_EN
            for (int k = 0; k < 3; k++)
                for (int j = 0; j < 4; j++) hist[k][j] = 0;
            pend_v  = 1'b0;
            first_m = 1'b1;
`endif
            started = 1'b1;
        end else begin
            exp_upd = 1'b0;
`ifdef ADC_PEAK_AVG_EN
            if (pend_v) begin
                for (int k = 0; k < 3; k++) begin
                    int s;
                    if (pend_first) begin
                        for (int j = 0; j < 4; j++) hist[k][j] = pend_res[k];
                    end else begin
                        for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
                        hist[k][0] = pend_res[k];
                    end
                    s = hist[k][0] + hist[k][1] + hist[k][2] + hist[k][3];
                    exp_val[k] = s / 4;
                end
                exp_upd = 1'b1;
                pend_v  = 1'b0;
            end
`endif
            if (i_clr) begin
                win_q.delete();
`ifdef ADC_PEAK_AVG_EN
                first_m = 1'b1;
`endif
            end else if (i_ad_valid) begin
                win_q.push_back(i_ad_data);
                if (win_q.size() == WIN) begin
                    mx = 0;
                    mn = 255;
                    foreach (win_q[j]) begin
                        if (int'(win_q[j]) > mx) mx = int'(win_q[j]);
                        if (int'(win_q[j]) < mn) mn = int'(win_q[j]);
                    end
                    win_q.delete();
`ifdef ADC_PEAK_AVG_EN
                    pend_res[0] = mx;
                    pend_res[1] = mn;
                    pend_res[2] = mx - mn;
                    pend_first  = first_m;
                    pend_v      = 1'b1;
                    first_m     = 1'b0;
`else
                    exp_val[0] = mx;
                    exp_val[1] = mn;
                    exp_val[2] = mx - mn;
                    exp_upd    = 1'b1;
`endif
                end
            end
        end
    end

    always @(negedge ad_clk) begin
        if (started) begin
            chk("upd", int'(o_upd), int'(exp_upd));
            chk("max", int'(o_ad_max), exp_val[0]);
            chk("min", int'(o_ad_min), exp_val[1]);
            chk("vpp", int'(o_ad_vpp), exp_val[2]);
            if (o_upd) begin
                upd_count++;
                $display("update t=%0t max=%0d min=%0d vpp=%0d", $time, o_ad_max, o_ad_min, o_ad_vpp);
            end
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d, input bit c);
        i_ad_valid = v;
        i_ad_data  = d;
        i_clr      = c;
        @(negedge ad_clk);
        i_ad_valid = 1'b0;
        i_clr      = 1'b0;
    endtask

    task automatic wait_upd(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_upd) begin
                ok = 1'b1;
                break;
            end
            @(negedge ad_clk);
        end
        chk({name, "_upd_seen"}, int'(ok), 1);
    endtask

    task automatic lit(input string name, input int mx, input int mn, input int vp);
        chk({name, "_max"}, int'(o_ad_max), mx);
        chk({name, "_min"}, int'(o_ad_min), mn);
        chk({name, "_vpp"}, int'(o_ad_vpp), vp);
    endtask

    task automatic pulse_end(input string name);
        @(negedge ad_clk);
        chk({name, "_upd_one_cycle"}, int'(o_upd), 0);
    endtask

    logic [7:0] basic[8] = '{8'd10, 8'd200, 8'd50, 8'd90, 8'd128, 8'd7, 8'd255, 8'd60};
    int vpp_lit[5] = '{100, 125, 150, 175, 200};

    initial begin
        int n0;
        repeat (2) @(negedge ad_clk);
        lit("reset", 0, 0, 0);
        chk("reset_upd", int'(o_upd), 0);
        rst_n = 1'b1;

        // Basic window
        for (int i = 0; i < 8; i++) cyc(1, basic[i], 0);
        wait_upd("basic");
        lit("basic", 255, 7, 248);
        pulse_end("basic");

        // Same data with gaps
        for (int i = 0; i < 8; i++) begin
            cyc(1, basic[i], 0);
            if (i < 7) cyc(0, 8'd0, 0);
        end
        wait_upd("gaps");
        lit("gaps", 255, 7, 248);
        pulse_end("gaps");

        // Flat, two back-to-back windows
        cyc(0, 8'd0, 1);
        n0 = upd_count;
        for (int i = 0; i < 16; i++) cyc(1, 8'd128, 0);
        wait_upd("flat");
        lit("flat", 128, 128, 0);
        pulse_end("flat");
        chk("flat_upd_count", upd_count - n0, 2);

        // Clear mid-window; the clr cycle also carries a sample that must be dropped
        for (int i = 0; i < 5; i++) cyc(1, 8'd250, 0);
        cyc(1, 8'd250, 1);
        lit("clr_hold", 128, 128, 0);
        for (int i = 0; i < 8; i++) cyc(1, 8'd100, 0);
        wait_upd("clr");
        lit("clr", 100, 100, 0);
        pulse_end("clr");

        // Clear on the closing sample suppresses the update
        n0 = upd_count;
        for (int i = 0; i < 7; i++) cyc(1, 8'd30, 0);
        cyc(1, 8'd30, 1);
        repeat (3) @(negedge ad_clk);
        chk("clr_close_no_upd", upd_count - n0, 0);
        lit("clr_close_hold", 100, 100, 0);
        for (int i = 0; i < 8; i++) cyc(1, 8'd40, 0);
        wait_upd("clr_close");
        lit("clr_close", 40, 40, 0);
        pulse_end("clr_close");

        // Reset mid-window after a completed window
        cyc(0, 8'd0, 1);
        for (int i = 0; i < 8; i++) cyc(1, basic[i], 0);
        wait_upd("pre_rst");
        lit("pre_rst", 255, 7, 248);
        repeat (2) @(negedge ad_clk);
        for (int i = 0; i < 3; i++) cyc(1, 8'd2, 0);
        rst_n = 1'b0;
        @(negedge ad_clk);
        rst_n = 1'b1;
        lit("rst", 0, 0, 0);
        chk("rst_upd", int'(o_upd), 0);
        for (int i = 0; i < 8; i++) cyc(1, 8'(60 + i), 0);
        wait_upd("post_rst");
        lit("post_rst", 67, 60, 7);
        pulse_end("post_rst");

`ifdef ADC_PEAK_AVG_EN
        cyc(0, 8'd0, 1);
        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < 8; i++) begin
                logic [7:0] d;
                if (w == 0) d = (i == 0) ? 8'd50 : (i == 1) ? 8'd150 : 8'd100;
                else        d = (i == 0) ? 8'd20 : (i == 1) ? 8'd220 : 8'd100;
                cyc(1, d, 0);
            end
            wait_upd("avg");
            chk("avg_vpp", int'(o_ad_vpp), vpp_lit[w]);
            pulse_end("avg");
        end
`endif

        repeat (3) @(negedge ad_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
